// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage : execute stage of the pipeline.
//   Takes the decoded control bundle and operands from the ID/EXE register. It
//   runs the ALU, keeps the NZCV status register and computes the branch
//   target. The result and the passthrough controls are registered into the
//   EXE/MEM pipeline register.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready = !mem_stall)
//   flush                 squash the incoming instruction
//   WB_EN MEM_R MEM_W B S decoded controls
//   EXE_CMD               4-bit ALU command
//   val_rn, val2          ALU operands (val2 already immediate-resolved)
//   st_val_in, dest_in    store data and destination register
//   pc_in, imm24          PC+4 and branch offset
//   mem_stall             memory stage back-pressure; holds the register
//   out_valid ... dest_o  registered EXE/MEM pipeline fields
//   br_taken, br_addr     registered branch outcome and target
//   status                NZCV register {N,Z,C,V}
// -----------------------------------------------------------------------------
module exe_stage #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              WB_EN,
  input  logic              MEM_R,
  input  logic              MEM_W,
  input  logic              B,
  input  logic              S,
  input  logic [3:0]        EXE_CMD,
  input  logic [DATA_W-1:0] val_rn,
  input  logic [DATA_W-1:0] val2,
  input  logic [DATA_W-1:0] st_val_in,
  input  logic [3:0]        dest_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [IMM_W-1:0]  imm24,
  input  logic              mem_stall,
  output logic              out_valid,
  output logic              wb_en_o,
  output logic              mem_r_o,
  output logic              mem_w_o,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] st_val_o,
  output logic [3:0]        dest_o,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_addr,
  output logic [3:0]        status
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam int         MSB     = DATA_W - 1;

  logic              out_valid_q, out_valid_d;
  logic              wb_en_q, wb_en_d, mem_r_q, mem_r_d, mem_w_q, mem_w_d;
  logic [DATA_W-1:0] alu_res_q, alu_res_d, st_val_q, st_val_d;
  logic [3:0]        dest_q, dest_d;
  logic              br_taken_q, br_taken_d;
  logic [DATA_W-1:0] br_addr_q, br_addr_d;
  logic [3:0]        status_q, status_d;

  logic              accept_s;
  logic              cin_s, borrow_s;
  logic [DATA_W:0]   add_ext_s, sub_ext_s;
  logic [DATA_W-1:0] res_s, br_target_s;
  logic              flags_ok_s, c_s, v_s;
  logic [3:0]        new_status_s;

  assign accept_s = in_valid & ~flush & ~mem_stall;
  assign in_ready = ~mem_stall;

  // Carry-in for ADC and borrow for SBC both come from the registered C flag.
  assign cin_s     = (EXE_CMD == CMD_ADC) ? status_q[1] : 1'b0;
  assign borrow_s  = (EXE_CMD == CMD_SBC) ? ~status_q[1] : 1'b0;
  // One extra bit captures carry-out / borrow-out.
  assign add_ext_s = {1'b0, val_rn} + {1'b0, val2} + {{DATA_W{1'b0}}, cin_s};
  assign sub_ext_s = {1'b0, val_rn} - {1'b0, val2} - {{DATA_W{1'b0}}, borrow_s};

  // Offset is sign-extended and scaled to a word address.
  assign br_target_s = pc_in + {{(DATA_W-IMM_W-2){imm24[IMM_W-1]}}, imm24, 2'b00};

  // ALU result and the flag values it would write; C/V default to held.
  always_comb begin
    res_s      = {DATA_W{1'b0}};
    flags_ok_s = 1'b1;
    c_s        = status_q[1];
    v_s        = status_q[0];
    case (EXE_CMD)
      CMD_MOV: res_s = val2;
      CMD_MVN: res_s = ~val2;
      CMD_ADD, CMD_ADC: begin
        res_s = add_ext_s[MSB:0];
        c_s   = add_ext_s[DATA_W];
        v_s   = (val_rn[MSB] == val2[MSB]) && (res_s[MSB] != val_rn[MSB]);
      end
      CMD_SUB, CMD_SBC: begin
        res_s = sub_ext_s[MSB:0];
        c_s   = ~sub_ext_s[DATA_W];  // C means no borrow
        v_s   = (val_rn[MSB] != val2[MSB]) && (res_s[MSB] != val_rn[MSB]);
      end
      CMD_AND: res_s = val_rn & val2;
      CMD_ORR: res_s = val_rn | val2;
      CMD_EOR: res_s = val_rn ^ val2;
      default: flags_ok_s = 1'b0;
    endcase
    new_status_s = {res_s[MSB], (res_s == {DATA_W{1'b0}}), c_s, v_s};
  end

  // Next state of the EXE/MEM register and the status register.
  always_comb begin
    out_valid_d = out_valid_q;
    wb_en_d     = wb_en_q;
    mem_r_d     = mem_r_q;
    mem_w_d     = mem_w_q;
    alu_res_d   = alu_res_q;
    st_val_d    = st_val_q;
    dest_d      = dest_q;
    br_taken_d  = br_taken_q;
    br_addr_d   = br_addr_q;
    if (mem_stall) begin
      // Stall beats flush: everything holds and the input is ignored.
      out_valid_d = out_valid_q;
    end else if (accept_s) begin
      out_valid_d = 1'b1;
      wb_en_d     = WB_EN & ~B;
      mem_r_d     = MEM_R & ~B;
      mem_w_d     = MEM_W & ~B;
      alu_res_d   = res_s;
      st_val_d    = st_val_in;
      dest_d      = dest_in;
      br_taken_d  = B;
      br_addr_d   = br_target_s;
    end else begin
      // Bubble: controls cleared, data fields keep stale values.
      out_valid_d = 1'b0;
      wb_en_d     = 1'b0;
      mem_r_d     = 1'b0;
      mem_w_d     = 1'b0;
      br_taken_d  = 1'b0;
    end
    if (accept_s && S && !B && flags_ok_s) begin
      status_d = new_status_s;
    end else begin
      status_d = status_q;
    end
  end

  // Pipeline and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      wb_en_q     <= 1'b0;
      mem_r_q     <= 1'b0;
      mem_w_q     <= 1'b0;
      alu_res_q   <= {DATA_W{1'b0}};
      st_val_q    <= {DATA_W{1'b0}};
      dest_q      <= 4'h0;
      br_taken_q  <= 1'b0;
      br_addr_q   <= {DATA_W{1'b0}};
      status_q    <= 4'h0;
    end else begin
      out_valid_q <= out_valid_d;
      wb_en_q     <= wb_en_d;
      mem_r_q     <= mem_r_d;
      mem_w_q     <= mem_w_d;
      alu_res_q   <= alu_res_d;
      st_val_q    <= st_val_d;
      dest_q      <= dest_d;
      br_taken_q  <= br_taken_d;
      br_addr_q   <= br_addr_d;
      status_q    <= status_d;
    end
  end

  assign out_valid = out_valid_q;
  assign wb_en_o   = wb_en_q;
  assign mem_r_o   = mem_r_q;
  assign mem_w_o   = mem_w_q;
  assign alu_res   = alu_res_q;
  assign st_val_o  = st_val_q;
  assign dest_o    = dest_q;
  assign br_taken  = br_taken_q;
  assign br_addr   = br_addr_q;
  assign status    = status_q;

endmodule
